// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter / control-flow unit.
package pc_pkg;

    // Control-flow class of the instruction in the current cycle.
    typedef enum logic [1:0] {
        OP_SEQ    = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2,
        OP_BRANCH = 2'd3
    } op_e;

    // What the return-address stack does at the next edge.
    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_POPPUSH = 2'd3
    } ras_act_e;

    // x1 (ra) and x5 (t0) are the ABI link registers.
    function automatic logic is_link_reg(input logic [4:0] idx);
        return (idx == 5'd1) || (idx == 5'd5);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry; a pop from an empty stack is ignored.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  ras_act_e        action_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic             empty;

    assign empty = (cnt_q == '0);

    // Pointer/count update and write-port selection for the requested action.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q + PTR_W'(1);
        case (action_i)
            RAS_PUSH: begin
                ptr_d = ptr_q + PTR_W'(1);
                wr_en = 1'b1;
                cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CNT_W'(1);
            end
            RAS_POP: begin
                if (!empty) begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAS_POPPUSH: begin
                if (!empty) begin
                    // Pop then push lands on the same slot: replace the top.
                    wr_ptr = ptr_q;
                    wr_en  = 1'b1;
                end else begin
                    // Pop of an empty stack is a no-op, leaving a plain push.
                    ptr_d = ptr_q + PTR_W'(1);
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge.
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage.
    // NOTE: the storage array is not reset; the count gates every read, so
    // stale contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_data_i;
        end
    end

    assign valid_o = !empty;
    assign top_o   = empty ? '0 : mem_q[ptr_q];

endmodule

// File: rtl/pc_control.sv
// Program counter and control-flow unit: next-PC selection, link write,
// misaligned-target trap and return-address prediction check.
module pc_control
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            br_taken_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_data_o,
    output logic            link_we_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_valid_o,
    output logic            ras_miss_o
);

    op_e             op;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            misalign_q, misalign_d;
    logic            ras_miss_q, ras_miss_d;
    logic [XLEN-1:0] seq_pc, rel_pc, jalr_sum, jalr_pc, target;
    logic            misaligned;
    logic            rd_link, rs1_link;
    ras_act_e        ras_act;

    assign op       = op_e'(op_i);
    assign seq_pc   = pc_q + XLEN'(4);
    assign rel_pc   = pc_q + imm_i;
    assign jalr_sum = rs1_val_i + imm_i;
    assign jalr_pc  = {jalr_sum[XLEN-1:1], 1'b0};
    assign rd_link  = is_link_reg(rd_idx_i);
    assign rs1_link = is_link_reg(rs1_idx_i);

    // Target selection and alignment check; a not-taken branch falls through.
    always_comb begin
        target = seq_pc;
        case (op)
            OP_JAL:    target = rel_pc;
            OP_JALR:   target = jalr_pc;
            OP_BRANCH: target = br_taken_i ? rel_pc : seq_pc;
            default:   target = seq_pc;
        endcase
        misaligned = (target[1:0] != 2'b00) && !(op == OP_BRANCH && !br_taken_i);
    end

    // Decode the RAS action from the link-register hint table.
    always_comb begin
        ras_act = RAS_NONE;
        if (!stall_i && !misaligned) begin
            case (op)
                OP_JAL: begin
                    if (rd_link) ras_act = RAS_PUSH;
                end
                OP_JALR: begin
                    if (rd_link && rs1_link) begin
                        ras_act = (rd_idx_i == rs1_idx_i) ? RAS_PUSH : RAS_POPPUSH;
                    end else if (rd_link) begin
                        ras_act = RAS_PUSH;
                    end else if (rs1_link) begin
                        ras_act = RAS_POP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next PC, trap capture and one-cycle pulse generation.
    always_comb begin
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        misalign_d = 1'b0;
        ras_miss_d = 1'b0;
        if (!stall_i) begin
            if (misaligned) begin
                pc_d       = TRAP_VECTOR;
                bad_addr_d = target;
                misalign_d = 1'b1;
            end else begin
                pc_d = target;
            end
            // Only a pop that actually removes an entry is checked.
            ras_miss_d = (ras_act == RAS_POP || ras_act == RAS_POPPUSH)
                         && ras_valid_o && (target != ras_top_o);
        end
    end

    // Architectural PC, trap address and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            bad_addr_q <= '0;
            misalign_q <= 1'b0;
            ras_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
            misalign_q <= misalign_d;
            ras_miss_q <= ras_miss_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .action_i    (ras_act),
        .push_data_i (seq_pc),
        .top_o       (ras_top_o),
        .valid_o     (ras_valid_o)
    );

    assign pc_o        = pc_q;
    assign link_data_o = seq_pc;
    assign link_we_o   = !stall_i && (op == OP_JAL || op == OP_JALR)
                         && (rd_idx_i != 5'd0) && !misaligned;
    assign misalign_o  = misalign_q;
    assign bad_addr_o  = bad_addr_q;
    assign ras_miss_o  = ras_miss_q;

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: table of instruction vectors with a
// scoreboard for the registered results, plus hand-written reset sequences.
module tb_pc_control;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] imm_i = '0;
    logic [31:0] rs1_val_i = '0;
    logic [4:0]  rs1_idx_i = '0;
    logic [4:0]  rd_idx_i = '0;
    logic        br_taken_i = 1'b0;
    logic [31:0] pc_o, link_data_o, bad_addr_o, ras_top_o;
    logic        link_we_o, misalign_o, ras_valid_o, ras_miss_o;

    int checks = 0;
    int errors = 0;

    pc_control dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .op_i        (op_i),
        .imm_i       (imm_i),
        .rs1_val_i   (rs1_val_i),
        .rs1_idx_i   (rs1_idx_i),
        .rd_idx_i    (rd_idx_i),
        .br_taken_i  (br_taken_i),
        .pc_o        (pc_o),
        .link_data_o (link_data_o),
        .link_we_o   (link_we_o),
        .misalign_o  (misalign_o),
        .bad_addr_o  (bad_addr_o),
        .ras_top_o   (ras_top_o),
        .ras_valid_o (ras_valid_o),
        .ras_miss_o  (ras_miss_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_first;
        logic        stall;
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] rs1_val;
        logic [31:0] imm;
        logic        taken;
        logic [31:0] e_link;
        logic        e_we;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_bad;
        logic        e_miss;
        logic        e_rv;
        logic [31:0] e_rt;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
        logic        miss;
        logic        rv;
        logic [31:0] rt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rf, input logic st, input op_e op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [31:0] rv1, input logic [31:0] imm,
                                input logic tk, input logic [31:0] e_link,
                                input logic e_we, input logic [31:0] e_pc,
                                input logic e_mis, input logic [31:0] e_bad,
                                input logic e_miss, input logic e_rv,
                                input logic [31:0] e_rt);
        vec_t v;
        v.rst_first = rf;  v.stall = st;   v.op = op;       v.rd = rd;
        v.rs1 = rs1;       v.rs1_val = rv1; v.imm = imm;     v.taken = tk;
        v.e_link = e_link; v.e_we = e_we;  v.e_pc = e_pc;   v.e_mis = e_mis;
        v.e_bad = e_bad;   v.e_miss = e_miss; v.e_rv = e_rv; v.e_rt = e_rt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles, check the reset state, release on a negedge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        stall_i = 1'b0;
        op_i = OP_SEQ;
        repeat (2) @(negedge clk);
        check({tag, "_rst_pc"}, pc_o, 32'h0);
        check({tag, "_rst_rv"}, 32'(ras_valid_o), 32'h0);
        check({tag, "_rst_rt"}, ras_top_o, 32'h0);
        check({tag, "_rst_mis"}, 32'(misalign_o), 32'h0);
        check({tag, "_rst_miss"}, 32'(ras_miss_o), 32'h0);
        check({tag, "_rst_bad"}, bad_addr_o, 32'h0);
        rst = 1'b0;
    endtask

    // Drive one instruction at a negedge, check combinational outputs, then
    // check the registered results just after the next rising edge.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        stall_i    = v.stall;
        op_i       = v.op;
        rd_idx_i   = v.rd;
        rs1_idx_i  = v.rs1;
        rs1_val_i  = v.rs1_val;
        imm_i      = v.imm;
        br_taken_i = v.taken;
        #1;
        check($sformatf("v%0d_link_data", id), link_data_o, v.e_link);
        check($sformatf("v%0d_link_we", id), 32'(link_we_o), 32'(v.e_we));
        e.id = id;  e.pc = v.e_pc;     e.mis = v.e_mis; e.bad = v.e_bad;
        e.miss = v.e_miss; e.rv = v.e_rv; e.rt = v.e_rt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d_pc", e.id), pc_o, e.pc);
        check($sformatf("v%0d_misalign", e.id), 32'(misalign_o), 32'(e.mis));
        check($sformatf("v%0d_bad_addr", e.id), bad_addr_o, e.bad);
        check($sformatf("v%0d_ras_miss", e.id), 32'(ras_miss_o), 32'(e.miss));
        check($sformatf("v%0d_ras_valid", e.id), 32'(ras_valid_o), 32'(e.rv));
        check($sformatf("v%0d_ras_top", e.id), ras_top_o, e.rt);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cur;
        int unsigned ret;

        // Basic SEQ then JAL x1 with push.
        vecs.push_back(mk(1, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h4,   0, 32'h4,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_JAL,    1, 0, 0, 32'h8, 0,  32'h8,   1, 32'hC,   0, 0, 0, 1, 32'h8));
        // JAL to non-link rd, then JAL x0.
        vecs.push_back(mk(1, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h4,   0, 32'h4,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_JAL,    2, 0, 0, 32'h20, 0, 32'h8,   1, 32'h24,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_JAL,    0, 0, 0, 32'h8, 0,  32'h28,  0, 32'h2C,  0, 0, 0, 0, 0));
        // Call/return hit, then call/return mispredict.
        vecs.push_back(mk(1, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h4,   0, 32'h4,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_JAL,    1, 0, 0, 32'h40, 0, 32'h8,   1, 32'h44,  0, 0, 0, 1, 32'h8));
        vecs.push_back(mk(0, 0, OP_JALR,   0, 1, 32'h8, 0, 0,  32'h48,  0, 32'h8,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_JAL,    1, 0, 0, 32'h40, 0, 32'hC,   1, 32'h48,  0, 0, 0, 1, 32'hC));
        vecs.push_back(mk(0, 0, OP_JALR,   0, 1, 32'h10, 0, 0, 32'h4C,  0, 32'h10,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h14,  0, 32'h14,  0, 0, 0, 0, 0));
        // Misaligned JALR trap, not-taken and taken branches.
        vecs.push_back(mk(0, 0, OP_JALR,   3, 6, 32'h103, 0, 0, 32'h18, 0, 32'h100, 1, 32'h102, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h104, 0, 32'h104, 0, 32'h102, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_BRANCH, 0, 0, 0, 32'h2, 0,  32'h108, 0, 32'h108, 0, 32'h102, 0, 0, 0));
        vecs.push_back(mk(0, 0, OP_BRANCH, 0, 0, 0, 32'h10, 1, 32'h10C, 0, 32'h118, 0, 32'h102, 0, 0, 0));
        // JALR hint variants: push, pop-then-push, push on rd==rs1.
        vecs.push_back(mk(0, 0, OP_JALR,   5, 2, 32'h201, 32'h10, 0, 32'h11C, 1, 32'h210, 0, 32'h102, 0, 1, 32'h11C));
        vecs.push_back(mk(0, 0, OP_JALR,   1, 5, 32'h11C, 0, 0, 32'h214, 1, 32'h11C, 0, 32'h102, 0, 1, 32'h214));
        vecs.push_back(mk(0, 0, OP_JALR,   1, 1, 32'h300, 0, 0, 32'h120, 1, 32'h300, 0, 32'h102, 0, 1, 32'h120));
        // Address wrap-around, misaligned taken branch, misaligned JAL x1 (no push).
        vecs.push_back(mk(0, 0, OP_JAL,    0, 0, 0, 32'hFFFF_FCFC, 0, 32'h304, 0, 32'hFFFF_FFFC, 0, 32'h102, 0, 1, 32'h120));
        vecs.push_back(mk(0, 0, OP_SEQ,    0, 0, 0, 0, 0,      32'h0,   0, 32'h0,   0, 32'h102, 0, 1, 32'h120));
        vecs.push_back(mk(0, 0, OP_BRANCH, 0, 0, 0, 32'h6, 1,  32'h4,   0, 32'h100, 1, 32'h6,   0, 1, 32'h120));
        vecs.push_back(mk(0, 0, OP_JAL,    1, 0, 0, 32'h2, 0,  32'h104, 0, 32'h100, 1, 32'h102, 0, 1, 32'h120));
        // Five nested calls overflow the 4-deep RAS, then five returns.
        for (int i = 0; i < 5; i++) begin
            cur = i * 32'h100;
            vecs.push_back(mk(i == 0, 0, OP_JAL, 1, 0, 0, 32'h100, 0, cur + 4, 1,
                              cur + 32'h100, 0, 0, 0, 1, cur + 4));
        end
        cur = 32'h500;
        for (int j = 0; j < 5; j++) begin
            ret = (4 - j) * 32'h100 + 4;
            vecs.push_back(mk(0, 0, OP_JALR, 0, 1, ret, 0, 0, cur + 4, 0, ret, 0, 0, 0,
                              j < 3, (j < 3) ? (3 - j) * 32'h100 + 4 : 32'h0));
            cur = ret;
        end

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst_first) do_reset($sformatf("v%0d", k));
            step(vecs[k], k);
        end

        // Stall holds PC and RAS; reset asserted mid-stall clears at once.
        do_reset("stall");
        step(mk(0, 0, OP_SEQ, 0, 0, 0, 0, 0, 32'h4, 0, 32'h4, 0, 0, 0, 0, 0), 100);
        step(mk(0, 0, OP_JAL, 1, 0, 0, 32'h8, 0, 32'h8, 1, 32'hC, 0, 0, 0, 1, 32'h8), 101);
        for (int s = 0; s < 3; s++) begin
            step(mk(0, 1, OP_JAL, 1, 0, 0, 32'h40, 0, 32'h10, 0, 32'hC, 0, 0, 0, 1, 32'h8), 102 + s);
        end
        step(mk(0, 1, OP_JALR, 1, 6, 32'h103, 0, 0, 32'h10, 0, 32'hC, 0, 0, 0, 1, 32'h8), 105);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc_o, 32'h0);
        check("async_rst_rv", 32'(ras_valid_o), 32'h0);
        check("async_rst_rt", ras_top_o, 32'h0);
        do_reset("stall_rel");
        step(mk(0, 0, OP_JAL, 1, 0, 0, 32'h40, 0, 32'h4, 1, 32'h40, 0, 0, 0, 1, 32'h4), 106);

        // A pending trap pulse is dropped by an asynchronous reset.
        step(mk(0, 0, OP_JALR, 0, 6, 32'h43, 0, 0, 32'h44, 0, 32'h100, 1, 32'h42, 0, 1, 32'h4), 107);
        #2;
        rst = 1'b1;
        #1;
        check("pulse_rst_mis", 32'(misalign_o), 32'h0);
        check("pulse_rst_bad", bad_addr_o, 32'h0);
        check("pulse_rst_pc", pc_o, 32'h0);
        do_reset("final");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
